testbus_monitor: RTL
====================

TESTBUS_MONITOR -- requirements
Module: testbus_monitor

Interface
REQ-001 Parameter DEPTH, default 16, capture buffer entries; power of two, 4..64.
REQ-002 Parameter LED_STRETCH, default 200000, cycles o_LED stays high after a trigger; >= 2.
REQ-003 i_CLK  in  1  200 MHz system clock; all logic on its rising edge.
REQ-004 i_RESET  in  1  synchronous, active-high reset.
REQ-005 iv_TEST  in  8  external 8-bit test bus; asynchronous to i_CLK.
REQ-006 iv_TRIG_MASK  in  8  trigger compare mask; 1 = bit participates.
REQ-007 iv_TRIG_VALUE  in  8  trigger compare value.
REQ-008 i_ARM  in  1  single-cycle pulse; start an acquisition.
REQ-009 i_RD_REQ  in  1  single-cycle pulse; request the next captured entry.
REQ-010 o_ARMED  out  1  high in ARMED state.
REQ-011 o_DONE  out  1  high in DONE state.
REQ-012 ov_RD_DATA  out  8  captured sample returned by a read.
REQ-013 o_RD_VALID  out  1  one-cycle strobe qualifying ov_RD_DATA.
REQ-014 ov_COUNT  out  7  entries written in the current acquisition.
REQ-015 o_LED  out  1  stretched trigger indicator.

Function
REQ-016 iv_TEST SHALL pass through a 2-flop synchronizer; s2 = second stage, s3 = s2 delayed one cycle.
REQ-017 FSM states SHALL be IDLE, ARMED, CAPTURE and DONE; reset state is IDLE.
REQ-018 IDLE: i_ARM -> ARMED next edge; ov_COUNT cleared, write pointer cleared, read pointer cleared.
REQ-019 ARMED: match = ((s2 ^ iv_TRIG_VALUE) & iv_TRIG_MASK) == 0; on match, s2 SHALL be written to entry 0 and the FSM SHALL enter CAPTURE on the same edge.
REQ-020 Mask 8'h00 SHALL trigger on the first ARMED cycle.
REQ-021 CAPTURE: whenever s2 != s3, s2 SHALL be written at the write pointer and ov_COUNT incremented; unchanged cycles SHALL not write.
REQ-022 On the edge where ov_COUNT reaches DEPTH, the FSM SHALL enter DONE; no further writes; ov_COUNT SHALL saturate at DEPTH.
REQ-023 DONE: i_RD_REQ SHALL produce o_RD_VALID=1 for exactly one cycle, one cycle later, with ov_RD_DATA = entry[read pointer]; the read pointer then increments.
REQ-024 The read that returns entry DEPTH-1 SHALL return the FSM to IDLE on the same edge that asserts o_RD_VALID.
REQ-025 i_RD_REQ outside DONE SHALL be ignored (no o_RD_VALID, no pointer change).
REQ-026 i_ARM in ARMED or CAPTURE SHALL be ignored; i_ARM in DONE SHALL abandon unread data and behave as REQ-018.
REQ-027 i_ARM and i_RD_REQ in the same DONE cycle: i_ARM wins, no o_RD_VALID.
REQ-028 ov_RD_DATA SHALL hold its last value between reads.
REQ-029 o_LED SHALL go high on the edge entering CAPTURE and stay high LED_STRETCH cycles; a new trigger while high SHALL reload the counter.
REQ-030 Pointers SHALL be log2(DEPTH) bits and SHALL never wrap within one acquisition.

Reset
REQ-031 i_RESET sampled high SHALL, on that edge, force IDLE and clear synchronizer flops, pointers, ov_COUNT and the LED counter.
REQ-032 Reset values: o_ARMED=0, o_DONE=0, ov_RD_DATA=8'h00, o_RD_VALID=0, ov_COUNT=0, o_LED=0.
REQ-033 Reset mid-CAPTURE or mid-readout SHALL discard the acquisition; buffer contents need not be cleared.
REQ-034 i_ARM/i_RD_REQ during reset SHALL be ignored.

Verification
REQ-035 Mask 8'hFF, value 8'hA5; drive 8'h00 then 8'hA5 after i_ARM -> trigger, entry 0 = 8'hA5, o_LED high, ov_COUNT=1, o_ARMED low.
REQ-036 After trigger, drive 15 distinct values each held 3 cycles (DEPTH=16) -> ov_COUNT=16, o_DONE=1; 16 i_RD_REQ pulses return values in order, o_RD_VALID one cycle after each, IDLE after 16th.
REQ-037 Held-constant bus for 100 cycles in CAPTURE -> ov_COUNT unchanged; i_RD_REQ in CAPTURE -> no o_RD_VALID.
REQ-038 i_ARM with i_RD_REQ in same DONE cycle after 3 reads -> ARMED, no o_RD_VALID, ov_COUNT=0.
REQ-039 i_RESET pulse mid-CAPTURE (ov_COUNT=7) -> next cycle all outputs at reset values; fresh i_ARM works normally.
REQ-040 LED_STRETCH=10: two triggers 6 cycles apart -> o_LED high continuously 16 cycles, then low.

Source files
------------

// File: rtl/testbus_monitor.sv
// Test-bus logic analyser: synchronises an external 8-bit bus, arms on request,
// triggers on a masked compare, records value changes into a small buffer and
// plays them back one entry per read request. A stretched LED marks triggers.
module testbus_monitor #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned LED_STRETCH = 200000
) (
    input  logic       i_CLK,
    input  logic       i_RESET,
    input  logic [7:0] iv_TEST,
    input  logic [7:0] iv_TRIG_MASK,
    input  logic [7:0] iv_TRIG_VALUE,
    input  logic       i_ARM,
    input  logic       i_RD_REQ,
    output logic       o_ARMED,
    output logic       o_DONE,
    output logic [7:0] ov_RD_DATA,
    output logic       o_RD_VALID,
    output logic [6:0] ov_COUNT,
    output logic       o_LED
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LedW = $clog2(LED_STRETCH + 1);

    localparam logic [6:0]      DepthCnt = 7'(DEPTH);
    localparam logic [PtrW-1:0] PtrLast  = PtrW'(DEPTH - 1);
    localparam logic [LedW-1:0] LedLoad  = LedW'(LED_STRETCH);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [7:0]      sync1_q, sync2_q, sync3_q;
    logic [6:0]      count_q, count_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic            rd_valid_q, rd_valid_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic [LedW-1:0] led_q;
    logic            led_load;

    logic            wr_en;
    logic [PtrW-1:0] wr_addr;
    logic            trig_match;

    logic [7:0] mem [DEPTH];

    assign trig_match = ((sync2_q ^ iv_TRIG_VALUE) & iv_TRIG_MASK) == 8'h00;

    // Two-flop synchroniser plus one extra stage for change detection.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
            sync3_q <= 8'h00;
        end else begin
            sync1_q <= iv_TEST;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Capture buffer; contents are never cleared, only overwritten.
    always_ff @(posedge i_CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= sync2_q;
        end
    end

    // FSM state, counters, pointers and read-return registers.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q    <= StIdle;
            count_q    <= 7'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next-state, buffer write control and read return.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        wr_en      = 1'b0;
        wr_addr    = wptr_q;
        led_load   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_ARM) begin
                    state_d = StArmed;
                    count_d = 7'd0;
                    wptr_d  = '0;
                    rptr_d  = '0;
                end
            end
            StArmed: begin
                if (trig_match) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    count_d  = 7'd1;
                    wptr_d   = PtrW'(1);
                    state_d  = StCapture;
                    led_load = 1'b1;
                end
            end
            StCapture: begin
                if (sync2_q != sync3_q) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 7'd1;
                    // Pointer is left alone on the final write so it never wraps.
                    if (count_q + 7'd1 == DepthCnt) begin
                        state_d = StDone;
                    end else begin
                        wptr_d = wptr_q + PtrW'(1);
                    end
                end
            end
            StDone: begin
                // Re-arm abandons unread data and takes priority over a read.
                if (i_ARM) begin
                    state_d = StArmed;
                    count_d = 7'd0;
                    wptr_d  = '0;
                    rptr_d  = '0;
                end else if (i_RD_REQ) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = mem[rptr_q];
                    if (rptr_q == PtrLast) begin
                        state_d = StIdle;
                    end else begin
                        rptr_d = rptr_q + PtrW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Trigger LED: reload on every trigger, count down to zero.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            led_q <= '0;
        end else if (led_load) begin
            led_q <= LedLoad;
        end else if (led_q != '0) begin
            led_q <= led_q - LedW'(1);
        end
    end

    assign o_ARMED    = (state_q == StArmed);
    assign o_DONE     = (state_q == StDone);
    assign ov_RD_DATA = rd_data_q;
    assign o_RD_VALID = rd_valid_q;
    assign ov_COUNT   = count_q;
    assign o_LED      = (led_q != '0);

endmodule
